tap_tempo_estimator: RTL and testbench
======================================

TAP_TEMPO_ESTIMATOR -- requirements
Module: tap_tempo_estimator

Interface
REQ-001 SHALL have parameter MIN_PERIOD, default 2_500_000, minimum accepted tap interval in clk cycles; shorter intervals are treated as bounce.
REQ-002 SHALL have parameter MAX_PERIOD, default 200_000_000, maximum tap interval in clk cycles before timeout.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tap  input  1  single-cycle, already-debounced, clk-synchronous beat (quarter-note) tap pulse.
REQ-006 SHALL have port load_tempo  output  1  one-cycle pulse; count_to_output is valid for the tempo divider.
REQ-007 SHALL have port count_to_output  output  32  divider terminal count: eighth-note period minus 1.
REQ-008 SHALL have port locked  output  1  high while a 4-interval average is held.
REQ-009 SHALL have port interval_count  output  3  number of valid intervals in history, 0..4.

Function
REQ-010 SHALL run a 32-bit interval counter: on an accepted tap it loads 1; otherwise it increments, saturating at MAX_PERIOD.
REQ-011 SHALL define the measured interval at an accepted tap as the counter value in that cycle, i.e. t1 - t0 cycles between taps.
REQ-012 SHALL implement states IDLE, FIRST, ACCUM, LOCKED, encoded in the shared package.
REQ-013 In IDLE, a tap SHALL start the counter and move to FIRST without updating history.
REQ-014 In FIRST/ACCUM/LOCKED, a tap with interval < MIN_PERIOD SHALL be ignored: no counter reload, no history change, no pulse.
REQ-015 A tap with MIN_PERIOD <= interval <= MAX_PERIOD SHALL be written into a 4-entry circular history, replacing the oldest entry once 4 entries exist.
REQ-016 On that write, interval_count SHALL saturate at 4 and the state SHALL move FIRST->ACCUM, or ACCUM->LOCKED when the count reaches 4.
REQ-017 SHALL keep a 34-bit running sum of the history, updated as sum + new - evicted, with no full re-add.
REQ-018 SHALL compute avg = floor(sum/4) and count_to_output = floor(avg/2) - 1, clamped to a minimum of 1.
REQ-019 In LOCKED, each accepted tap SHALL update count_to_output and pulse load_tempo exactly one cycle after the tap cycle.
REQ-020 load_tempo SHALL never pulse in IDLE, FIRST or ACCUM, and SHALL never pulse on consecutive cycles.
REQ-021 If the counter equals MAX_PERIOD with no tap in that cycle, the block SHALL go to IDLE, clear history, and set interval_count to 0.
REQ-022 On timeout, count_to_output SHALL hold its last value and locked SHALL deassert the next cycle.
REQ-023 A tap in the same cycle the counter equals MAX_PERIOD SHALL be accepted as a valid interval; timeout SHALL NOT occur.
REQ-024 The first tap after a timeout SHALL be treated as an IDLE tap per REQ-013.
REQ-025 locked SHALL be high exactly when the state is LOCKED.

Reset
REQ-026 reset SHALL take priority over tap in the same cycle.
REQ-027 On reset: state IDLE, counter 0, history and sum 0, interval_count 0, load_tempo 0, locked 0, count_to_output 0.
REQ-028 Reset asserted mid-measurement SHALL discard all partial history; the next post-reset tap is a first tap.

Structure
REQ-029 Shared package tempo_pkg SHALL hold the state enum, HIST_DEPTH=4, and the SUM_W=34 constant.
REQ-030 Interval counter with saturation and timeout flag SHALL be sub-module tap_interval_counter; history, sum and FSM stay in the top.
REQ-031 All outputs SHALL be registered; no combinational path from tap to any output.

Verification (MIN_PERIOD=4, MAX_PERIOD=1000)
REQ-032 Five taps spaced 100 cycles -> load_tempo pulses once, 1 cycle after the 5th tap; count_to_output=49; locked=1; interval_count=4.
REQ-033 Locked at 100-cycle spacing, then one tap at spacing 200 -> sum=500, avg=125, count_to_output=61, one load_tempo pulse.
REQ-034 Tap 2 cycles after a valid tap (bounce) -> ignored; the following tap 100 cycles after the valid tap still yields interval 100.
REQ-035 No tap for 1000 cycles after the last tap -> IDLE, locked=0, interval_count=0, count_to_output held; a tap exactly at counter=1000 instead is accepted.
REQ-036 Reset asserted in the same cycle as the 5th tap -> no load_tempo, all outputs 0; 5 fresh taps are needed to lock.
REQ-037 Intervals 101,101,101,102 -> sum=405, avg=101, count_to_output=49 (floor rules).

Source files
------------

// File: rtl/tempo_pkg.sv
// Shared definitions for the tap tempo estimator.
//   tempo_state_e : estimator FSM states
//   HIST_DEPTH    : number of intervals averaged
//   SUM_W         : width of the running interval sum
//   CNT_W         : width of the interval counter and divider count
//   divider_count : running sum -> eighth-note divider terminal count
package tempo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    ACCUM,
    LOCKED
  } tempo_state_e;

  localparam int unsigned HIST_DEPTH = 4;
  localparam int unsigned SUM_W      = 34;
  localparam int unsigned CNT_W      = 32;
  localparam logic [2:0]  HIST_FULL  = 3'(HIST_DEPTH);

  // floor(floor(sum/4)/2) == sum >> 3; result is that minus 1, never below 1.
  function automatic logic [CNT_W-1:0] divider_count(input logic [SUM_W-1:0] sum);
    logic [CNT_W-1:0] half;
    half = CNT_W'(sum >> 3);
    return (half > CNT_W'(2)) ? half - CNT_W'(1) : CNT_W'(1);
  endfunction

endpackage

// File: rtl/tap_interval_counter.sv
// Interval counter between accepted taps.
//   clk, reset : clock, synchronous active-high reset (counter -> 0)
//   load_i     : accepted tap; counter restarts at 1
//   count_o    : current interval count, saturates at MAX_PERIOD
//   sat_o      : counter is at MAX_PERIOD (timeout candidate)
module tap_interval_counter
  import tempo_pkg::*;
#(
  parameter int unsigned MAX_PERIOD = 200_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (load_i)
      cnt_d = CNT_W'(1);
    else if (cnt_q >= MAX_CNT)
      cnt_d = MAX_CNT;
    else
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign sat_o   = (cnt_q == MAX_CNT);

endmodule

// File: rtl/tap_tempo_estimator.sv
// Tap tempo estimator: averages the last four tap intervals and produces an
// eighth-note divider terminal count.
//   clk, reset      : clock, synchronous active-high reset (priority over tap)
//   tap             : single-cycle debounced beat tap
//   load_tempo      : one-cycle pulse, count_to_output freshly updated
//   count_to_output : eighth-note period minus 1 (held across timeouts)
//   locked          : four-interval average held
//   interval_count  : valid intervals in history, 0..4
// MIN_PERIOD must be at least 2 so accepted taps are never adjacent cycles.
module tap_tempo_estimator
  import tempo_pkg::*;
#(
  parameter int unsigned MIN_PERIOD = 2_500_000,
  parameter int unsigned MAX_PERIOD = 200_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tap,
  output logic        load_tempo,
  output logic [31:0] count_to_output,
  output logic        locked,
  output logic [2:0]  interval_count
);

  tempo_state_e     state_q;
  logic [CNT_W-1:0] hist_q [HIST_DEPTH];
  logic [1:0]       wp_q;
  logic [2:0]       count_q;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] cto_q;
  logic             load_q;
  logic             locked_q;

  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             accept;
  logic             timeout;
  logic             cnt_load;
  logic [CNT_W-1:0] evicted;
  logic [SUM_W-1:0] sum_d;
  logic [CNT_W-1:0] cto_d;

  tap_interval_counter #(
    .MAX_PERIOD(MAX_PERIOD)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .load_i (cnt_load),
    .count_o(cnt),
    .sat_o  (sat)
  );

  always_comb begin
    // Counter saturates at MAX_PERIOD, so the upper bound always holds.
    accept   = tap && (state_q != IDLE) && (cnt >= MIN_PERIOD);
    // A tap landing on the saturated count is a valid interval, not a timeout.
    timeout  = !tap && (state_q != IDLE) && sat;
    cnt_load = tap && ((state_q == IDLE) || accept);
    evicted  = (count_q == HIST_FULL) ? hist_q[wp_q] : '0;
    sum_d    = sum_q + SUM_W'(cnt) - SUM_W'(evicted);
    cto_d    = divider_count(sum_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
      wp_q     <= '0;
      count_q  <= '0;
      sum_q    <= '0;
      cto_q    <= '0;
      load_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (state_q == IDLE) begin
        locked_q <= 1'b0;
        if (tap) state_q <= FIRST;
      end else if (accept) begin
        hist_q[wp_q] <= cnt;
        wp_q         <= wp_q + 2'd1;
        sum_q        <= sum_d;
        if (count_q != HIST_FULL) count_q <= count_q + 3'd1;
        if (count_q >= HIST_FULL - 3'd1) begin
          state_q  <= LOCKED;
          locked_q <= 1'b1;
          cto_q    <= cto_d;
          load_q   <= 1'b1;
        end else begin
          state_q  <= ACCUM;
          locked_q <= 1'b0;
        end
      end else if (timeout) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
        for (int unsigned i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        wp_q     <= '0;
        count_q  <= '0;
        sum_q    <= '0;
      end
    end
  end

  assign load_tempo      = load_q;
  assign count_to_output = cto_q;
  assign locked          = locked_q;
  assign interval_count  = count_q;

endmodule

// File: tb/tb_tap_tempo_estimator.sv
module tb_tap_tempo_estimator;

  localparam int unsigned MINP = 4;
  localparam int unsigned MAXP = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tap = 1'b0;
  logic        load_tempo;
  logic [31:0] count_to_output;
  logic        locked;
  logic [2:0]  interval_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: tap times and a queue of the last four intervals.
  bit     m_active = 1'b0;
  longint m_edge = 0;
  longint m_last = 0;
  longint m_q[$];
  longint m_cto = 0;
  bit     m_load = 1'b0;

  tap_tempo_estimator #(
    .MIN_PERIOD(MINP),
    .MAX_PERIOD(MAXP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tap            (tap),
    .load_tempo     (load_tempo),
    .count_to_output(count_to_output),
    .locked         (locked),
    .interval_count (interval_count)
  );

  always #5 clk = ~clk;

  function automatic longint calc_cto(input longint s);
    longint c;
    c = (s / 4) / 2 - 1;
    return (c < 1) ? 1 : c;
  endfunction

  task automatic model_edge(input bit t, input bit r);
    longint iv;
    longint s;
    m_edge++;
    m_load = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_q.delete();
      m_cto = 0;
    end else if (!m_active) begin
      if (t) begin
        m_active = 1'b1;
        m_last   = m_edge;
      end
    end else begin
      iv = m_edge - m_last;
      if (t && iv >= MINP) begin
        m_q.push_back(iv);
        if (m_q.size() > 4) void'(m_q.pop_front());
        m_last = m_edge;
        if (m_q.size() == 4) begin
          s = 0;
          foreach (m_q[i]) s += m_q[i];
          m_cto  = calc_cto(s);
          m_load = 1'b1;
        end
      end else if (!t && iv == MAXP) begin
        m_active = 1'b0;
        m_q.delete();
      end
    end
  endtask

  task automatic step(input bit t, input bit r);
    tap   = t;
    reset = r;
    @(posedge clk);
    model_edge(t, r);
    #1;
    tap   = 1'b0;
    reset = 1'b0;
    if (load_tempo) pulses++;
  endtask

  task automatic wait_tap(input int gap);
    repeat (gap - 1) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic lock_at(input int gap);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (4) wait_tap(gap);
  endtask

  task automatic test_reset;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checks++; if (load_tempo !== 1'b0) begin errors++; $display("FAIL reset_load: got %0d expected 0", load_tempo); end
    checks++; if (count_to_output !== 32'd0) begin errors++; $display("FAIL reset_cto: got %0d expected 0", count_to_output); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0d expected 0", locked); end
    checks++; if (interval_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", interval_count); end
  endtask

  task automatic test_lock;
    step(1'b0, 1'b1);
    pulses = 0;
    step(1'b1, 1'b0);
    repeat (3) wait_tap(100);
    checks++; if (pulses != 0) begin errors++; $display("FAIL lock_early_pulse: got %0d expected 0", pulses); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early_locked: got %0d expected 0", locked); end
    checks++; if (interval_count !== 3'd3) begin errors++; $display("FAIL lock_early_count: got %0d expected 3", interval_count); end
    wait_tap(100);
    checks++; if (load_tempo !== 1'b1) begin errors++; $display("FAIL lock_load: got %0d expected 1", load_tempo); end
    checks++; if (count_to_output !== 32'd49) begin errors++; $display("FAIL lock_cto: got %0d expected 49", count_to_output); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %0d expected 1", locked); end
    checks++; if (interval_count !== 3'd4) begin errors++; $display("FAIL lock_count: got %0d expected 4", interval_count); end
    step(1'b0, 1'b0);
    checks++; if (load_tempo !== 1'b0) begin errors++; $display("FAIL lock_pulse_width: got %0d expected 0", load_tempo); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL lock_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_tempo_change;
    lock_at(100);
    pulses = 0;
    wait_tap(200);
    checks++; if (load_tempo !== 1'b1) begin errors++; $display("FAIL change_load: got %0d expected 1", load_tempo); end
    checks++; if (count_to_output !== 32'd61) begin errors++; $display("FAIL change_cto: got %0d expected 61", count_to_output); end
    step(1'b0, 1'b0);
    checks++; if (pulses != 1) begin errors++; $display("FAIL change_pulses: got %0d expected 1", pulses); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL change_locked: got %0d expected 1", locked); end
  endtask

  task automatic test_bounce;
    lock_at(100);
    pulses = 0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (load_tempo !== 1'b0) begin errors++; $display("FAIL bounce_load: got %0d expected 0", load_tempo); end
    checks++; if (interval_count !== 3'd4) begin errors++; $display("FAIL bounce_count: got %0d expected 4", interval_count); end
    repeat (97) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (load_tempo !== 1'b1) begin errors++; $display("FAIL bounce_next_load: got %0d expected 1", load_tempo); end
    checks++; if (count_to_output !== 32'd49) begin errors++; $display("FAIL bounce_next_cto: got %0d expected 49", count_to_output); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_timeout;
    lock_at(100);
    repeat (999) step(1'b0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL timeout_pre_locked: got %0d expected 1", locked); end
    step(1'b0, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_locked: got %0d expected 0", locked); end
    checks++; if (interval_count !== 3'd0) begin errors++; $display("FAIL timeout_count: got %0d expected 0", interval_count); end
    checks++; if (count_to_output !== 32'd49) begin errors++; $display("FAIL timeout_cto_held: got %0d expected 49", count_to_output); end
    step(1'b1, 1'b0);
    checks++; if (interval_count !== 3'd0) begin errors++; $display("FAIL timeout_first_tap: got %0d expected 0", interval_count); end
    wait_tap(100);
    checks++; if (interval_count !== 3'd1) begin errors++; $display("FAIL timeout_second_tap: got %0d expected 1", interval_count); end
    // Tap landing exactly on the saturated count is a valid 1000-cycle interval.
    lock_at(100);
    pulses = 0;
    repeat (999) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++; if (load_tempo !== 1'b1) begin errors++; $display("FAIL edge_tap_load: got %0d expected 1", load_tempo); end
    checks++; if (count_to_output !== 32'd161) begin errors++; $display("FAIL edge_tap_cto: got %0d expected 161", count_to_output); end
    step(1'b0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL edge_tap_locked: got %0d expected 1", locked); end
    checks++; if (interval_count !== 3'd4) begin errors++; $display("FAIL edge_tap_count: got %0d expected 4", interval_count); end
  endtask

  task automatic test_reset_collision;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (3) wait_tap(100);
    pulses = 0;
    repeat (99) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    checks++; if (load_tempo !== 1'b0) begin errors++; $display("FAIL rst_tap_load: got %0d expected 0", load_tempo); end
    checks++; if (count_to_output !== 32'd0) begin errors++; $display("FAIL rst_tap_cto: got %0d expected 0", count_to_output); end
    checks++; if (interval_count !== 3'd0) begin errors++; $display("FAIL rst_tap_count: got %0d expected 0", interval_count); end
    step(1'b1, 1'b0);
    repeat (3) wait_tap(100);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_relock_early: got %0d expected 0", locked); end
    wait_tap(100);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rst_relock: got %0d expected 1", locked); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL rst_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_floor_and_clamp;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    wait_tap(101); wait_tap(101); wait_tap(101); wait_tap(102);
    checks++; if (count_to_output !== 32'd49) begin errors++; $display("FAIL floor_cto: got %0d expected 49", count_to_output); end
    lock_at(MINP);
    checks++; if (count_to_output !== 32'd1) begin errors++; $display("FAIL clamp_cto: got %0d expected 1", count_to_output); end
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    wait_tap(MINP - 1);
    checks++; if (interval_count !== 3'd0) begin errors++; $display("FAIL below_min: got %0d expected 0", interval_count); end
    step(1'b1, 1'b0);
    checks++; if (interval_count !== 3'd1) begin errors++; $display("FAIL at_min: got %0d expected 1", interval_count); end
  endtask

  task automatic test_random;
    int  gap;
    int  sel;
    bit  prev_load;
    step(1'b0, 1'b1);
    prev_load = 1'b0;
    for (int ev = 0; ev < 80; ev++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 1)      gap = int'($urandom_range(1, 6));
      else if (sel <= 7) gap = int'($urandom_range(60, 300));
      else if (sel == 8) gap = int'($urandom_range(995, 1005));
      else               gap = 0;
      for (int k = 0; k <= gap; k++) begin
        if (gap == 0)      step(1'b0, 1'b1);
        else if (k == 0)   continue;
        else               step(k == gap, 1'b0);
        checks++; if (load_tempo !== m_load) begin errors++; $display("FAIL rnd_load: got %0d expected %0d", load_tempo, m_load); end
        checks++; if (count_to_output !== 32'(m_cto)) begin errors++; $display("FAIL rnd_cto: got %0d expected %0d", count_to_output, m_cto); end
        checks++; if (locked !== (m_active && m_q.size() == 4)) begin errors++; $display("FAIL rnd_locked: got %0d expected %0d", locked, (m_active && m_q.size() == 4)); end
        checks++; if (interval_count !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", interval_count, m_q.size()); end
        checks++; if (load_tempo && prev_load) begin errors++; $display("FAIL rnd_back_to_back: got 1 expected 0"); end
        prev_load = load_tempo;
      end
    end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_tempo_change;
    test_bounce;
    test_timeout;
    test_reset_collision;
    test_floor_and_clamp;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
